// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, constants and baud-rate helper
package uart_pkg;
    localparam int UART_DATA_BITS = 8;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_state_e;
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction
endpackage

// File: rtl/uart_rx_byte_if.sv
// uart_rx_byte_if: serial line in, received byte and status strobes out
// ports: rx (line), data (held byte), ready (byte strobe), frame_err (bad stop strobe), busy (frame in progress)
`timescale 1ns/1ps
interface uart_rx_byte_if;
    import uart_pkg::*;
    logic                      rx;
    logic [UART_DATA_BITS-1:0] data;
    logic                      ready;
    logic                      frame_err;
    logic                      busy;
    modport master (input rx, output data, ready, frame_err, busy);
    modport slave (output rx, input data, ready, frame_err, busy);
endinterface

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for one asynchronous input
// ports: clk, rst (sync, active-high, loads RST_VAL), d (async in), q (synchronized out)
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk) begin
        if (rst) begin
            m <= RST_VAL;
            q <= RST_VAL;
        end else begin
            m <= d;
            q <= m;
        end
    end
endmodule

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 LSB-first serial receiver with 3-sample majority vote per bit
// ports: clk, rst (sync, active-high), bus.master: rx in; data, ready, frame_err, busy out
`timescale 1ns/1ps
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLK_HZ       = 62500000,
    parameter int BAUD         = 115200,
    parameter int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD)
) (
    input logic            clk,
    input logic            rst,
    uart_rx_byte_if.master bus
);
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    if (CLKS_PER_BIT < 8) begin : g_bad_rate
        $error("uart_rx_byte: CLKS_PER_BIT must be at least 8");
    end

    uart_state_e               state, state_n;
    logic                      rx_s, v0, v1, vote, at_vote, at_end, ready_n, ferr_n;
    logic [CW-1:0]             cnt;
    logic [2:0]                bit_idx;
    logic [UART_DATA_BITS-1:0] sr, data;
    logic                      ready, frame_err;

    sync_2ff #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(bus.rx), .q(rx_s));

    assign at_vote = cnt == CW'(HALF + 1);
    assign at_end  = cnt == CW'(CLKS_PER_BIT - 1);
    // third sample is the live rx_s at HALF+1, so the vote is ready on that cycle
    assign vote    = (v0 & v1) | (v0 & rx_s) | (v1 & rx_s);

    assign bus.data      = data;
    assign bus.ready     = ready;
    assign bus.frame_err = frame_err;
    assign bus.busy      = state != IDLE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        ready_n = 1'b0;
        ferr_n  = 1'b0;
        case (state)
            IDLE:  state_n = rx_s ? IDLE : START;
            START: state_n = (at_vote && vote) ? IDLE : at_end ? DATA : START;
            DATA:  state_n = (at_end && bit_idx == 3'(UART_DATA_BITS - 1)) ? STOP : DATA;
            // decide mid-cell so a following start bit in the late stop cell is not missed
            STOP: begin
                state_n = at_vote ? (vote ? IDLE : BREAK) : STOP;
                ready_n = at_vote && vote;
                ferr_n  = at_vote && !vote;
            end
            BREAK:   state_n = rx_s ? IDLE : BREAK;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            bit_idx   <= '0;
            sr        <= '0;
            v0        <= 1'b1;
            v1        <= 1'b1;
            data      <= '0;
            ready     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ready     <= ready_n;
            frame_err <= ferr_n;
            cnt       <= (state == IDLE || state == BREAK || at_end) ? '0 : cnt + 1'b1;
            if (cnt == CW'(HALF - 1)) v0 <= rx_s;
            if (cnt == CW'(HALF)) v1 <= rx_s;
            if (state == DATA && at_vote) sr <= {vote, sr[UART_DATA_BITS-1:1]};
            if (state == START) bit_idx <= '0;
            else if (state == DATA && at_end && bit_idx != 3'(UART_DATA_BITS - 1)) bit_idx <= bit_idx + 3'd1;
            if (ready_n) data <= sr;
        end
    end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed vector bench for uart_rx_byte at 10 clocks per bit
`timescale 1ns/1ps
module tb_uart_rx_byte;
    typedef struct {
        logic [7:0] b;
        int         bit_ns;
        logic       stop;
        int         exp_rdy;
        int         exp_ferr;
        logic [7:0] exp_data;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int cyc = 0, n_ready = 0, n_ferr = 0, n_both = 0, n_busy = 0, last_lat = 0;
    int applied = 0, miscompares = 0, t_start = 0;
    logic [7:0] rdata [0:63];

    uart_rx_byte_if u ();
    uart_rx_byte #(.CLK_HZ(1000000), .BAUD(100000)) dut (.clk(clk), .rst(rst), .bus(u.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (u.ready) begin
            rdata[n_ready % 64] = u.data;
            last_lat = cyc - t_start;
            n_ready++;
        end
        if (u.frame_err) n_ferr++;
        if (u.ready && u.frame_err) n_both++;
        if (u.busy) n_busy++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        applied++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input int bit_ns, input logic stop);
        t_start = cyc;
        u.rx = 1'b0;
        #(bit_ns);
        for (int i = 0; i < 8; i++) begin
            u.rx = b[i];
            #(bit_ns);
        end
        u.rx = stop;
        #(bit_ns);
    endtask

    initial begin
        vec_t vt [6];
        int r0, f0, b0, bad;
        vt[0] = '{8'h5A, 100, 1'b1, 1, 0, 8'h5A};
        vt[1] = '{8'hC3, 104, 1'b1, 1, 0, 8'hC3};
        vt[2] = '{8'hC3,  96, 1'b1, 1, 0, 8'hC3};
        vt[3] = '{8'hA5, 100, 1'b0, 0, 1, 8'hC3};
        vt[4] = '{8'h0F, 100, 1'b1, 1, 0, 8'h0F};
        vt[5] = '{8'h80, 100, 1'b1, 1, 0, 8'h80};
        u.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_data", int'(u.data), 8'h00);
        chk("reset_ready", int'(u.ready), 0);
        chk("reset_frame_err", int'(u.frame_err), 0);
        chk("reset_busy", int'(u.busy), 0);

        r0 = n_ready; f0 = n_ferr;
        send_frame(8'h61, 100, 1'b1);
        repeat (20) @(negedge clk);
        chk("a_ready_count", n_ready - r0, 1);
        chk("a_latency_96_101", int'(last_lat >= 96 && last_lat <= 101), 1);
        chk("a_data", int'(u.data), 8'h61);
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (u.data !== 8'h61) bad++;
        end
        chk("a_hold_500", bad, 0);
        chk("a_frame_err", n_ferr - f0, 0);

        r0 = n_ready; f0 = n_ferr;
        send_frame(8'h33, 100, 1'b1);
        send_frame(8'h66, 100, 1'b1);
        send_frame(8'h20, 100, 1'b1);
        repeat (20) @(negedge clk);
        chk("b2b_ready_count", n_ready - r0, 3);
        chk("b2b_byte0", int'(rdata[r0 % 64]), 8'h33);
        chk("b2b_byte1", int'(rdata[(r0 + 1) % 64]), 8'h66);
        chk("b2b_byte2", int'(rdata[(r0 + 2) % 64]), 8'h20);
        chk("b2b_frame_err", n_ferr - f0, 0);

        r0 = n_ready; f0 = n_ferr; b0 = n_busy;
        u.rx = 1'b0;
        repeat (3) @(negedge clk);
        u.rx = 1'b1;
        repeat (30) @(negedge clk);
        chk("glitch_busy_seen", int'(n_busy > b0), 1);
        chk("glitch_ready", n_ready - r0, 0);
        chk("glitch_frame_err", n_ferr - f0, 0);
        chk("glitch_data", int'(u.data), 8'h20);
        chk("glitch_busy_end", int'(u.busy), 0);

        for (int k = 0; k < 6; k++) begin
            r0 = n_ready; f0 = n_ferr;
            send_frame(vt[k].b, vt[k].bit_ns, vt[k].stop);
            u.rx = 1'b1;
            repeat (30) @(negedge clk);
            chk($sformatf("vec%0d_ready", k), n_ready - r0, vt[k].exp_rdy);
            chk($sformatf("vec%0d_frame_err", k), n_ferr - f0, vt[k].exp_ferr);
            chk($sformatf("vec%0d_data", k), int'(u.data), int'(vt[k].exp_data));
            chk($sformatf("vec%0d_busy", k), int'(u.busy), 0);
        end

        r0 = n_ready; f0 = n_ferr;
        send_frame(8'hA5, 100, 1'b0);
        repeat (40) @(negedge clk);
        chk("break_busy_held", int'(u.busy), 1);
        chk("break_frame_err", n_ferr - f0, 1);
        chk("break_ready", n_ready - r0, 0);
        chk("break_data", int'(u.data), 8'h80);
        u.rx = 1'b1;
        repeat (10) @(negedge clk);
        chk("break_exit_busy", int'(u.busy), 0);
        send_frame(8'h0F, 100, 1'b1);
        repeat (20) @(negedge clk);
        chk("break_next_data", int'(u.data), 8'h0F);
        chk("break_next_ready", n_ready - r0, 1);

        r0 = n_ready; f0 = n_ferr;
        fork
            send_frame(8'hF0, 100, 1'b1);
            begin
                #550;
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        join
        repeat (30) @(negedge clk);
        chk("rst_mid_ready", n_ready - r0, 0);
        chk("rst_mid_frame_err", n_ferr - f0, 0);
        chk("rst_mid_data", int'(u.data), 8'h00);
        chk("rst_mid_busy", int'(u.busy), 0);
        send_frame(8'h7E, 100, 1'b1);
        repeat (20) @(negedge clk);
        chk("rst_next_data", int'(u.data), 8'h7E);
        chk("rst_next_ready", n_ready - r0, 1);

        chk("ready_and_frame_err_overlap", n_both, 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Asynchronous serial receiver, 8N1, LSB first.
- Sits directly upstream of the serial boot loader and the UART control registers.
- Converts the raw rx pin into a held byte plus a one-cycle ready strobe.
- Downstream logic may sample `data` combinationally on the strobe cycle and on any later cycle. `data` holds until the next good frame completes.

Parameters:
- CLK_HZ, 62500000, system clock frequency in Hz.
- BAUD, 115200, line rate in bits/s.
- CLKS_PER_BIT, CLK_HZ/BAUD (integer division), clocks per bit cell. Elaboration error if < 8.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- rx  input  1  asynchronous serial line, idle high
- data  output  8  last correctly framed byte, held stable
- ready  output  1  one-cycle pulse: new byte valid in `data`
- frame_err  output  1  one-cycle pulse: stop bit sampled low
- busy  output  1  high from start-bit detection until return to IDLE

Behaviour:
- Reset values: data=8'h00, ready=0, frame_err=0, busy=0, state=IDLE.
  - Synchronizer flops reset to 1 (idle line).
- Input sync: rx passes through a 2-flop synchronizer giving rx_s, 2 cycles of latency. The FSM uses only rx_s.
- Bit counter: cnt counts 0..CLKS_PER_BIT-1, width $clog2(CLKS_PER_BIT). HALF = CLKS_PER_BIT/2.
- Sampling: majority vote of rx_s taken at cnt = HALF-1, HALF and HALF+1 within each bit cell. The decision is registered at HALF+1.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - busy=0.
  - rx_s==0 → START, cnt=0, busy=1.
- START:
  - Voted start bit = 1 → false start. Return to IDLE with no pulse on any output.
  - Voted start bit = 0 → continue to the end of the cell, then → DATA with bit index 0.
- DATA:
  - Each cell's voted bit is shifted into the shift register MSB, right shift, so the first received bit lands in data[0].
  - After bit index 7 completes its cell → STOP. Bit index width is 3, no wrap.
- STOP, decision taken at vote time (HALF+1), not at the end of the cell:
  - Vote = 1: data <= shift register, ready=1 for exactly one cycle, → IDLE.
    - The next start edge may therefore be detected in the second half of the stop cell. This tolerates sender clock up to ~+4%.
  - Vote = 0: frame_err=1 for exactly one cycle, data unchanged, → BREAK.
- BREAK: wait until rx_s==1, then → IDLE. No ready is emitted during a held-low break condition.
- ready and frame_err are never high in the same cycle.
- Latency: ready asserts 2 (sync) + 9×CLKS_PER_BIT + HALF + 1 cycles after the rx falling edge of the start bit, ±1.
- Reset mid-frame: state returns to IDLE and the partial byte is discarded. data is forced to 0, and no pulse is emitted.
- If the line is still low after reset, the FSM treats it as a new start bit. The resulting frame_err is acceptable.
- Back-to-back frames with zero idle time are received without loss.
- No internal FIFO. The consumer must accept one byte per frame time (e.g. ~86.8 µs at 115200).

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, DATA, STOP, BREAK).
  - Function clks_per_bit(clk_hz, baud).
  - Constant UART_DATA_BITS = 8.
  - Later reused by the UART transmitter.
- One sub-module, sync_2ff: 2-flop synchronizer with reset value parameter.
  - Reused for other async inputs (buttons, SD card detect).

Test Plan (bench uses CLK_HZ=1000000, BAUD=100000, so CLKS_PER_BIT=10):
- Send 0x61 ('a') with clean timing → exactly one ready pulse ~97 cycles after the start edge. data=8'h61 and stays 8'h61 for 500 idle cycles. frame_err never asserts.
- Send 0x33, 0x66, 0x20 back to back, stop bit immediately followed by the next start bit → three ready pulses, in order, with data 8'h33, 8'h66, 8'h20. No frame_err.
- 3-cycle low glitch on the idle line → busy pulses briefly, then no ready and no frame_err. data unchanged. A subsequent 0x5A is received correctly.
- Frame 0xA5 with the stop bit driven low, line then held low for 40 cycles before returning high → one frame_err pulse, no ready, data keeps its previous value. The FSM sits in BREAK until the line goes high. A following 0x0F is received.
- Assert rst for 1 cycle during data bit 4 of a frame → no ready or frame_err from that frame, data=8'h00, busy=0. The next full frame 0x7E is received with data=8'h7E.
- Bit-rate skew: sender period 10.4 and 9.6 clocks per bit for byte 0xC3 → data=8'hC3 in both cases, ready once each.
